// File: rtl/instr_prefetch_if.sv
// Bus bundle between the instruction prefetch unit, the instruction memory
// and the decode stage.
//
// Handshake semantics:
//   imem_req/imem_addr : a request is issued in every cycle imem_req is high;
//                        the memory always accepts it.
//   imem_rvalid        : one response per high cycle, in request order.
//   if_valid/if_stall  : the head instruction transfers in a cycle where
//                        if_valid is high and if_stall is low; while if_stall
//                        is high the head (if_pc/if_instr) is held stable.
interface instr_prefetch_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;
  logic             if_stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             proto_err;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, proto_err,
    input  imem_rvalid, imem_rdata, if_stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, proto_err,
    output imem_rvalid, imem_rdata, if_stall, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch front end: sequential fetch address generation,
// credit-limited request issue, in-order PC tag tracking, a small
// instruction queue toward decode, and redirect flush with stale-response
// discard.
module instr_prefetch_unit #(
  parameter int          PC_W     = 9,
  parameter int          INS_W    = 32,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  instr_prefetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  q_pc    [DEPTH];
  logic [INS_W-1:0] q_instr [DEPTH];
  logic [PW-1:0]    q_rd, q_wr;
  logic [CW-1:0]    count, inflight, discard;
  logic [PC_W-1:0]  tag_pc  [DEPTH];
  logic [PW-1:0]    tag_rd, tag_wr;
  logic             proto_err_q;

  logic issue, rsp, push, pop;
  logic [CW:0] credits_used;

  // Request/response/pop qualification; redirect suppresses issue and pop.
  always_comb begin
    credits_used = {1'b0, count} + {1'b0, inflight};
    issue = !reset && !bus.redirect && (credits_used < (CW+1)'(DEPTH));
    rsp   = bus.imem_rvalid && (inflight != '0);
    push  = rsp && !bus.redirect && (discard == '0);
    pop   = (count != '0) && !bus.if_stall && !bus.redirect;
  end

  // Outputs come straight from registered queue state; zero when empty.
  always_comb begin
    bus.imem_req  = issue;
    bus.imem_addr = fetch_pc;
    bus.if_valid  = (count != '0);
    bus.if_pc     = (count != '0) ? q_pc[q_rd]    : '0;
    bus.if_instr  = (count != '0) ? q_instr[q_rd] : '0;
    bus.proto_err = proto_err_q;
  end

  // Storage arrays: tag FIFO written on issue, queue written on push.
  always_ff @(posedge clk) begin
    if (issue) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      q_pc[q_wr]    <= tag_pc[tag_rd];
      q_instr[q_wr] <= bus.imem_rdata;
    end
  end

  // Control state: fetch PC, pointers, occupancy, discard and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= PC_W'(RESET_PC);
      q_rd        <= '0;
      q_wr        <= '0;
      count       <= '0;
      inflight    <= '0;
      discard     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (bus.imem_rvalid && (inflight == '0)) proto_err_q <= 1'b1;
      if (issue) tag_wr <= tag_wr + PW'(1);
      if (rsp)   tag_rd <= tag_rd + PW'(1);
      inflight <= inflight + CW'(issue) - CW'(rsp);
      if (bus.redirect) begin
        // Everything still owed after this cycle belongs to the old path.
        fetch_pc <= bus.redirect_pc;
        q_rd     <= '0;
        q_wr     <= '0;
        count    <= '0;
        discard  <= inflight - CW'(rsp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_W'(4);
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
        if (push) q_wr <= q_wr + PW'(1);
        if (pop)  q_rd <= q_rd + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
